// File: rtl/pixel_centroid_accum_if.sv
// Stream input and result record channel of the pixel centroid accumulator.
// master: the video source / result consumer side; slave: the accumulator.
interface pixel_centroid_accum_if #(
  parameter int SUM_W = 32,
  parameter int CNT_W = 20
);
  logic [23:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tuser;
  logic             s_axis_tlast;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum_x;
  logic [SUM_W-1:0] res_sum_y;
  logic [CNT_W-1:0] res_count;
  logic             res_err;
  logic             res_overflow;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast, res_ready,
    input  s_axis_tready, res_valid, res_sum_x, res_sum_y, res_count, res_err, res_overflow
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast, res_ready,
    output s_axis_tready, res_valid, res_sum_x, res_sum_y, res_count, res_err, res_overflow
  );
endinterface

// File: rtl/pixel_centroid_accum.sv
// Pixel centroid accumulator: classifies RGB888 stream pixels against
// per-channel thresholds and accumulates sum_x, sum_y and match count over a
// frame, handing one record per frame to the register block.
module pixel_centroid_accum #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = 10,
  parameter int CNT_W      = 20,
  parameter int SUM_W      = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  pixel_centroid_accum_if.slave bus,
  input  logic [23:0]           thr_lo,
  input  logic [23:0]           thr_hi,
  input  logic                  enable
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Inclusive per-channel window test on all three colour channels.
  function automatic logic pixel_match(input logic [23:0] pix,
                                       input logic [23:0] lo,
                                       input logic [23:0] hi);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if ((pix[c*8 +: 8] < lo[c*8 +: 8]) || (pix[c*8 +: 8] > hi[c*8 +: 8]))
        ok = 1'b0;
    end
    return ok;
  endfunction

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic               tready_q;
  logic [COORD_W-1:0] x_q, y_q, x_d, y_d, cur_x, cur_y;
  logic [SUM_W-1:0]   sx_q, sy_q, sx_d, sy_d, base_sx, base_sy;
  logic [CNT_W-1:0]   cnt_q, cnt_d, base_cnt;
  logic               err_q, err_d, base_err;
  logic               beat, start, take, line_end, frame_end, hit;

  logic               res_valid_q, res_err_q, res_ovf_q;
  logic [SUM_W-1:0]   res_sx_q, res_sy_q;
  logic [CNT_W-1:0]   res_cnt_q;

  // Next state and next accumulator values for the current beat.
  // A start-of-frame beat (from IDLE with enable, or a restart in ACCUM)
  // is evaluated as pixel (0,0) against cleared accumulators.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    frame_end = 1'b0;

    beat     = bus.s_axis_tvalid && tready_q;
    start    = beat && bus.s_axis_tuser && ((state_q == ACCUM) || enable);
    take     = beat && ((state_q == ACCUM) || start);
    hit      = pixel_match(bus.s_axis_tdata, thr_lo, thr_hi);
    cur_x    = start ? '0 : x_q;
    cur_y    = start ? '0 : y_q;
    base_sx  = start ? '0 : sx_q;
    base_sy  = start ? '0 : sy_q;
    base_cnt = start ? '0 : cnt_q;
    base_err = start ? 1'b0 : err_q;
    // A missing tlast at the last column still closes the line.
    line_end = bus.s_axis_tlast || (cur_x == X_LAST);

    if (take) begin
      sx_d   = hit ? base_sx + SUM_W'(cur_x) : base_sx;
      sy_d   = hit ? base_sy + SUM_W'(cur_y) : base_sy;
      cnt_d  = hit ? sat_inc(base_cnt) : base_cnt;
      err_d  = base_err | (bus.s_axis_tlast != (cur_x == X_LAST));
      state_d = ACCUM;
      if (line_end) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          y_d       = '0;
          frame_end = 1'b1;
          state_d   = IDLE;
        end else begin
          y_d = cur_y + COORD_W'(1);
        end
      end else begin
        x_d = cur_x + COORD_W'(1);
        y_d = cur_y;
      end
    end
  end

  // Frame FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Position counters and accumulators; tready rises on the first edge after reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tready_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      x_q      <= x_d;
      y_q      <= y_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Result record: loads at end of frame unless an unaccepted record is held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      res_valid_q <= 1'b0;
      res_sx_q    <= '0;
      res_sy_q    <= '0;
      res_cnt_q   <= '0;
      res_err_q   <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else if (frame_end) begin
      if (!res_valid_q || bus.res_ready) begin
        res_valid_q <= 1'b1;
        res_sx_q    <= sx_d;
        res_sy_q    <= sy_d;
        res_cnt_q   <= cnt_d;
        res_err_q   <= err_d;
      end else begin
        res_ovf_q   <= 1'b1;
      end
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_sum_x     = res_sx_q;
  assign bus.res_sum_y     = res_sy_q;
  assign bus.res_count     = res_cnt_q;
  assign bus.res_err       = res_err_q;
  assign bus.res_overflow  = res_ovf_q;

endmodule

// File: tb/tb_pixel_centroid_accum.sv
// Bench for pixel_centroid_accum on a 4x3 image: directed scenarios with
// literal expectations, then randomized traffic against a frame-level model.
module tb_pixel_centroid_accum;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int SUM_W = 32;
  localparam int CNT_W = 20;
  localparam longint SUM_MASK = 64'h0000_0000_FFFF_FFFF;
  localparam longint CNT_MAX  = (64'd1 << CNT_W) - 1;

  logic        tb_ACLK    = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic [23:0] thr_lo, thr_hi;
  logic        enable;
  logic        rand_ready = 1'b0;
  logic        rr_rand    = 1'b0;
  logic        dir_ready  = 1'b0;
  int          checks = 0;
  int          errors = 0;

  pixel_centroid_accum_if #(.SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();
  assign bus.res_ready = rand_ready ? rr_rand : dir_ready;

  pixel_centroid_accum #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(10), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .bus(bus),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .enable(enable)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_act = 0, m_err = 0, m_fin = 0;
  int     m_x = 0, m_y = 0;
  longint m_sx = 0, m_sy = 0, m_cnt = 0;
  bit     e_tready = 0, e_valid = 0, e_err = 0, e_ovf = 0;
  longint e_sx = 0, e_sy = 0, e_cnt = 0;

  function automatic bit in_window(input logic [23:0] p, input logic [23:0] lo, input logic [23:0] hi);
    bit ok;
    ok = 1;
    for (int c = 0; c < 3; c++)
      if (p[c*8 +: 8] < lo[c*8 +: 8] || p[c*8 +: 8] > hi[c*8 +: 8]) ok = 0;
    return ok;
  endfunction

  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      m_act = 0; m_err = 0; m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_cnt = 0;
      e_tready = 0; e_valid = 0; e_err = 0; e_ovf = 0; e_sx = 0; e_sy = 0; e_cnt = 0;
    end else begin
      m_fin = 0;
      if (bus.s_axis_tvalid && e_tready) begin
        if (bus.s_axis_tuser && (m_act || enable)) begin
          m_act = 1; m_err = 0; m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_cnt = 0;
        end
        if (m_act) begin
          if (in_window(bus.s_axis_tdata, thr_lo, thr_hi)) begin
            m_sx = (m_sx + m_x) & SUM_MASK;
            m_sy = (m_sy + m_y) & SUM_MASK;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
          if (bus.s_axis_tlast != (m_x == W-1)) m_err = 1;
          if (bus.s_axis_tlast || m_x == W-1) begin
            if (m_y == H-1) begin m_fin = 1; m_act = 0; end
            m_x = 0;
            m_y++;
          end else begin
            m_x++;
          end
        end
      end
      if (m_fin) begin
        if (!e_valid || bus.res_ready) begin
          e_valid = 1; e_sx = m_sx; e_sy = m_sy; e_cnt = m_cnt; e_err = m_err;
        end else begin
          e_ovf = 1;
        end
      end else if (e_valid && bus.res_ready) begin
        e_valid = 0;
      end
      e_tready = 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge tb_ACLK) begin
    check("tready", bus.s_axis_tready, e_tready);
    check("res_valid", bus.res_valid, e_valid);
    check("res_overflow", bus.res_overflow, e_ovf);
    if (e_valid) begin
      check("res_sum_x", bus.res_sum_x, e_sx);
      check("res_sum_y", bus.res_sum_y, e_sy);
      check("res_count", bus.res_count, e_cnt);
      check("res_err", bus.res_err, e_err);
    end
  end

  always @(posedge tb_ACLK) begin
    #1;
    rr_rand = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus ----------------
  function automatic logic [23:0] pix(input int kind, input int x, input int y);
    if (kind == 0) return {8'(x * 40), 8'(y * 60), 8'h55};
    return (x == 2 && y == 1) ? 24'hFF0000 : 24'h000000;
  endfunction

  function automatic logic [23:0] rand_lo();
    return {8'($urandom_range(0, 128)), 8'($urandom_range(0, 128)), 8'($urandom_range(0, 128))};
  endfunction

  function automatic logic [23:0] rand_hi();
    return {8'($urandom_range(96, 255)), 8'($urandom_range(96, 255)), 8'($urandom_range(96, 255))};
  endfunction

  task automatic send(input logic [23:0] d, input logic u, input logic l);
    bus.s_axis_tdata  = d;
    bus.s_axis_tuser  = u;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic frame_beats(input int kind, input int a, input int b);
    for (int i = a; i < b; i++)
      send(pix(kind, i % W, i / W), i == 0, (i % W) == W-1);
  endtask

  task automatic consume();
    dir_ready = 1'b1;
    @(posedge tb_ACLK); #1;
    dir_ready = 1'b0;
  endtask

  task automatic check_rec(input string tag, input longint cnt, input longint sx,
                           input longint sy, input logic err);
    check({tag, "_valid"}, bus.res_valid, 1);
    check({tag, "_count"}, bus.res_count, cnt);
    check({tag, "_sum_x"}, bus.res_sum_x, sx);
    check({tag, "_sum_y"}, bus.res_sum_y, sy);
    check({tag, "_err"},   bus.res_err, err);
  endtask

  initial begin
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 0; bus.s_axis_tuser = 0; bus.s_axis_tlast = 0;
    thr_lo = 24'h000000; thr_hi = 24'hFFFFFF; enable = 1'b1;

    repeat (2) @(posedge tb_ACLK);
    #1;
    check("rst_tready", bus.s_axis_tready, 0);
    check("rst_valid", bus.res_valid, 0);
    #2 tb_ARESETN = 1'b1;
    @(posedge tb_ACLK); #1;
    check("tready_after_rst", bus.s_axis_tready, 1);

    // 1: full match, latency 1
    frame_beats(0, 0, W*H-1);
    check("s1_valid_before_last", bus.res_valid, 0);
    frame_beats(0, W*H-1, W*H);
    check_rec("s1", 12, 18, 12, 0);
    consume();
    check("s1_valid_drop", bus.res_valid, 0);

    // 2: single matching pixel
    thr_lo = 24'h800000; thr_hi = 24'hFF3F3F;
    frame_beats(1, 0, W*H);
    check_rec("s2", 1, 2, 1, 0);
    consume();

    // 3: two frames without acceptance
    thr_lo = 24'h000000; thr_hi = 24'hFFFFFF;
    frame_beats(0, 0, W*H);
    thr_lo = 24'h800000; thr_hi = 24'hFF3F3F;
    frame_beats(1, 0, W*H);
    check_rec("s3_held", 12, 18, 12, 0);
    check("s3_overflow", bus.res_overflow, 1);
    dir_ready = 1'b1;
    #1 check_rec("s3_read", 12, 18, 12, 0);
    @(posedge tb_ACLK); #1;
    dir_ready = 1'b0;
    check("s3_valid_drop", bus.res_valid, 0);

    // 4: early tlast on line 0, then a clean frame
    thr_lo = 24'h000000; thr_hi = 24'hFFFFFF;
    send(pix(0, 0, 0), 1, 0);
    send(pix(0, 1, 0), 0, 0);
    send(pix(0, 2, 0), 0, 1);
    for (int i = W; i < W*H; i++) send(pix(0, i % W, i / W), 0, (i % W) == W-1);
    check_rec("s4_err", 11, 15, 12, 1);
    consume();
    frame_beats(0, 0, W*H);
    check_rec("s4_clean", 12, 18, 12, 0);
    consume();

    // 5: tuser at pixel (1,1) restarts the frame
    frame_beats(0, 0, W + 1);
    frame_beats(0, 0, W*H-1);
    check("s5_no_early_record", bus.res_valid, 0);
    frame_beats(0, W*H-1, W*H);
    check_rec("s5", 12, 18, 12, 0);
    consume();
    repeat (3) @(posedge tb_ACLK);
    #1 check("s5_single_record", bus.res_valid, 0);

    // 6: asynchronous reset mid-frame with a record pending
    frame_beats(0, 0, W*H);
    frame_beats(0, 0, W + 3);
    bus.s_axis_tdata = pix(0, 3, 1); bus.s_axis_tlast = 1'b1; bus.s_axis_tvalid = 1'b1;
    #3 tb_ARESETN = 1'b0;
    #1;
    check("s6_tready", bus.s_axis_tready, 0);
    check("s6_valid", bus.res_valid, 0);
    check("s6_sum_x", bus.res_sum_x, 0);
    check("s6_sum_y", bus.res_sum_y, 0);
    check("s6_count", bus.res_count, 0);
    check("s6_err", bus.res_err, 0);
    check("s6_overflow", bus.res_overflow, 0);
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    @(posedge tb_ACLK);
    #3 tb_ARESETN = 1'b1;
    @(posedge tb_ACLK); #1;
    check("s6_tready_back", bus.s_axis_tready, 1);
    frame_beats(0, 0, W*H);
    check_rec("s6", 12, 18, 12, 0);
    check("s6_no_overflow", bus.res_overflow, 0);
    consume();

    // Randomized traffic, checked by the per-cycle compare
    rand_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      enable = ($urandom_range(0, 7) != 0);
      thr_lo = rand_lo();
      thr_hi = rand_hi();
      repeat ($urandom_range(0, 2)) send(24'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      for (int i = 0; i < W*H; i++) begin
        int x, e;
        logic u, l;
        x = i % W;
        e = $urandom_range(0, 29);
        u = (i == 0) || (e == 2);
        l = (x == W-1);
        if (e == 0 && x == W-1) l = 1'b0;
        if (e == 1 && x == 1) l = 1'b1;
        if ($urandom_range(0, 7) == 0) begin thr_lo = rand_lo(); thr_hi = rand_hi(); end
        repeat ($urandom_range(0, 2)) begin @(posedge tb_ACLK); #1; end
        send(24'($urandom), u, l);
      end
    end
    rand_ready = 1'b0;
    dir_ready  = 1'b1;
    repeat (4) @(posedge tb_ACLK);
    #1 check("final_drained", bus.res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
